// File: rtl/mips_pkg.sv
// Shared encodings and default widths for the pipeline memory-port logic.
package mips_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_MEM  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wait_timer.sv
// Clear/enable cycle counter; expired flags that LIMIT busy cycles have elapsed.
module wait_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory between the fetch and
// data ports, with a single outstanding transaction and a hung-access watchdog.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_stall,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [1:0]        owner,
  input  logic              err_clr,
  output logic              bus_err
);

  arb_state_e        state_q, state_d;
  logic              m_req_d, m_we_d, i_ack_d, d_ack_d, bus_err_d;
  logic              last_mem, last_mem_d;
  logic [ADDR_W-1:0] m_addr_d;
  logic [DATA_W-1:0] m_wdata_d, i_rdata_d, d_rdata_d, done_rdata;
  logic [1:0]        owner_d;
  logic              timer_clr, timer_en, timer_expired, abort;

  wait_timer #(
    .LIMIT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Next-state, arbitration and datapath update
  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req;
    m_we_d     = m_we;
    m_addr_d   = m_addr;
    m_wdata_d  = m_wdata;
    i_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    i_rdata_d  = i_rdata;
    d_rdata_d  = d_rdata;
    owner_d    = owner;
    last_mem_d = last_mem;
    timer_clr  = 1'b0;
    timer_en   = 1'b0;
    abort      = 1'b0;
    done_rdata = '0;

    case (state_q)
      ST_IDLE: begin
        timer_clr = 1'b1;
        // A tie goes to whichever port was not served last
        if (d_req && (!i_req || !last_mem)) begin
          state_d    = ST_BUSY_D;
          m_req_d    = 1'b1;
          m_we_d     = d_we;
          m_addr_d   = d_addr;
          m_wdata_d  = d_wdata;
          owner_d    = OWN_MEM;
          last_mem_d = 1'b1;
        end else if (i_req) begin
          state_d    = ST_BUSY_I;
          m_req_d    = 1'b1;
          m_we_d     = 1'b0;
          m_addr_d   = i_addr;
          m_wdata_d  = '0;
          owner_d    = OWN_IF;
          last_mem_d = 1'b0;
        end
      end

      ST_BUSY_I, ST_BUSY_D: begin
        if (m_ack || timer_expired) begin
          abort      = !m_ack;
          done_rdata = (m_ack && !m_we) ? m_rdata : '0;
          state_d    = ST_IDLE;
          m_req_d    = 1'b0;
          m_we_d     = 1'b0;
          owner_d    = OWN_IDLE;
          timer_clr  = 1'b1;
          if (state_q == ST_BUSY_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = done_rdata;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = done_rdata;
          end
        end else begin
          timer_en = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort sets the sticky error even if a clear arrives in the same cycle
    bus_err_d = bus_err;
    if (abort) begin
      bus_err_d = 1'b1;
    end else if (err_clr) begin
      bus_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
      owner    <= OWN_IDLE;
      bus_err  <= 1'b0;
      last_mem <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_req    <= m_req_d;
      m_we     <= m_we_d;
      m_addr   <= m_addr_d;
      m_wdata  <= m_wdata_d;
      i_ack    <= i_ack_d;
      d_ack    <= d_ack_d;
      i_rdata  <= i_rdata_d;
      d_rdata  <= d_rdata_d;
      owner    <= owner_d;
      bus_err  <= bus_err_d;
      last_mem <= last_mem_d;
    end
  end

  // Stalls depend only on the request and the registered ack
  assign i_stall = i_req & ~i_ack;
  assign d_stall = d_req & ~d_ack;

endmodule
